morse_seq_detector: RTL and testbench

Parametrised successor to `sos_detector`. It consumes the classified symbol stream from `dash_dot` (`ready` strobe plus 2-bit code) and matches it against a runtime-programmable Morse pattern of up to `MAX_SYMS` symbols. The default pattern is SOS. It adds:
- an idle-timeout history flush,
- selectable overlapping or non-overlapping matching,
- a saturating match counter,
- illegal-code detection.

---
 rtl/morse_pkg.sv | 23 ++
 rtl/morse_idle_timer.sv | 28 ++
 rtl/morse_seq_detector.sv | 127 ++++++++++++
 tb/tb_morse_seq_detector.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared Morse symbol codes and the default SOS pattern.
// Also used by dash_dot and sos_detector.
package morse_pkg;

    localparam logic [1:0] SYM_DOT     = 2'b00;
    localparam logic [1:0] SYM_ILLEGAL = 2'b01;
    localparam logic [1:0] SYM_SPACE   = 2'b10;
    localparam logic [1:0] SYM_DASH    = 2'b11;

    localparam int SOS_LEN = 11;

    // Oldest symbol in the top pair, newest in [1:0].
    localparam logic [21:0] SOS_PATTERN = {
        SYM_DOT,  SYM_DOT,  SYM_DOT,  SYM_SPACE,
        SYM_DASH, SYM_DASH, SYM_DASH, SYM_SPACE,
        SYM_DOT,  SYM_DOT,  SYM_DOT
    };

    function automatic logic is_illegal(input logic [1:0] s);
        return s == SYM_ILLEGAL;
    endfunction

endpackage

// File: rtl/morse_idle_timer.sv
// Idle-cycle counter; expire pulses on the TIMEOUT-th
// consecutive run cycle and the count restarts from 0.
module morse_idle_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    assign expire = run && !clear && (count == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clear || expire) begin
            count <= '0;
        end else if (run) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/morse_seq_detector.sv
// Programmable Morse pattern matcher over the dash_dot symbol
// stream, with idle flush, overlap mode and saturating counter.
module morse_seq_detector
    import morse_pkg::*;
#(
    parameter int MAX_SYMS = 16,
    parameter int CNT_W    = 8,
    parameter int TIMEOUT  = 1024,
    parameter int OVERLAP  = 1,
    parameter int LEN_W    = $clog2(MAX_SYMS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  sym_valid,
    input  logic [1:0]            sym,
    input  logic                  cfg_we,
    input  logic [LEN_W-1:0]      cfg_len,
    input  logic [2*MAX_SYMS-1:0] cfg_pattern,
    output logic                  match,
    output logic [CNT_W-1:0]      match_count,
    output logic [2*MAX_SYMS-1:0] history,
    output logic [LEN_W-1:0]      fill,
    output logic                  err_illegal
);

    localparam int HW = 2 * MAX_SYMS;
    localparam logic [LEN_W-1:0] FULL    = LEN_W'(MAX_SYMS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [LEN_W-1:0] RST_LEN =
        (SOS_LEN > MAX_SYMS) ? FULL : LEN_W'(SOS_LEN);
    localparam logic [HW-1:0] RST_PAT = HW'(SOS_PATTERN);

    logic [LEN_W-1:0] len_q;
    logic [HW-1:0]    pattern_q;
    logic [HW-1:0]    cmp_mask;
    logic [HW-1:0]    hist_shift;
    logic [LEN_W-1:0] fill_inc;
    logic [LEN_W-1:0] len_clamped;
    logic             attempt;
    logic             accept;
    logic             illegal;
    logic             hit;
    logic             timer_run;
    logic             timer_clear;
    logic             expire;

    // Configuration takes priority over any symbol on the same cycle.
    assign attempt = enable && sym_valid && !cfg_we;
    assign accept  = attempt && !is_illegal(sym);
    assign illegal = attempt && is_illegal(sym);

    assign hist_shift  = {history[HW-3:0], sym};
    assign fill_inc    = (fill == FULL) ? fill : fill + 1'b1;
    assign len_clamped = (cfg_len > FULL) ? FULL : cfg_len;

    always_comb begin
        cmp_mask = '0;
        for (int i = 0; i < MAX_SYMS; i++) begin
            if (i < int'(len_q)) begin
                cmp_mask[2*i +: 2] = 2'b11;
            end
        end
    end

    // Compare against the history as it will look after this accept.
    assign hit = accept
              && (len_q != '0)
              && (fill_inc >= len_q)
              && (((hist_shift ^ pattern_q) & cmp_mask) == '0);

    assign timer_run   = enable && (fill != '0);
    assign timer_clear = !enable || sym_valid || cfg_we || (fill == '0);

    morse_idle_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_idle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (timer_run),
        .clear (timer_clear),
        .expire(expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            len_q       <= RST_LEN;
            pattern_q   <= RST_PAT;
            history     <= '0;
            fill        <= '0;
            err_illegal <= 1'b0;
            match       <= 1'b0;
            match_count <= '0;
        end else if (cfg_we) begin
            len_q       <= len_clamped;
            pattern_q   <= cfg_pattern;
            history     <= '0;
            fill        <= '0;
            err_illegal <= 1'b0;
            match       <= 1'b0;
        end else if (illegal) begin
            history     <= '0;
            fill        <= '0;
            err_illegal <= 1'b1;
            match       <= 1'b0;
        end else if (accept) begin
            match <= hit;
            if (hit && match_count != CNT_MAX) begin
                match_count <= match_count + 1'b1;
            end
            if (hit && OVERLAP == 0) begin
                history <= '0;
                fill    <= '0;
            end else begin
                history <= hist_shift;
                fill    <= fill_inc;
            end
        end else begin
            match <= 1'b0;
            if (expire) begin
                history <= '0;
                fill    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_morse_seq_detector.sv
// Bench: overlap and non-overlap detectors against a queue-based
// model, directed scenarios then randomized traffic.
module tb_morse_seq_detector;
    import morse_pkg::*;

    localparam int MAX = 16;
    localparam int TO  = 20;
    localparam int LW  = $clog2(MAX + 1);
    localparam int HW  = 2 * MAX;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          sym_valid = 1'b0;
    logic [1:0]    sym = 2'b00;
    logic          cfg_we = 1'b0;
    logic [LW-1:0] cfg_len = '0;
    logic [HW-1:0] cfg_pattern = '0;

    logic          match_a, match_b;
    logic [1:0]    count_a;
    logic [7:0]    count_b;
    logic [HW-1:0] hist_a, hist_b;
    logic [LW-1:0] fill_a, fill_b;
    logic          err_a, err_b;

    always #5 clk = ~clk;

    morse_seq_detector #(
        .MAX_SYMS(MAX), .CNT_W(2), .TIMEOUT(TO), .OVERLAP(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .sym_valid(sym_valid), .sym(sym), .cfg_we(cfg_we),
        .cfg_len(cfg_len), .cfg_pattern(cfg_pattern),
        .match(match_a), .match_count(count_a), .history(hist_a),
        .fill(fill_a), .err_illegal(err_a)
    );

    morse_seq_detector #(
        .MAX_SYMS(MAX), .CNT_W(8), .TIMEOUT(TO), .OVERLAP(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .sym_valid(sym_valid), .sym(sym), .cfg_we(cfg_we),
        .cfg_len(cfg_len), .cfg_pattern(cfg_pattern),
        .match(match_b), .match_count(count_b), .history(hist_b),
        .fill(fill_b), .err_illegal(err_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: history as a queue of symbols, newest at back.
    int            m_len;
    logic [HW-1:0] m_pat;
    logic [1:0]    m_q [2][$];
    int            m_idle [2];
    int            m_cnt [2];
    bit            m_err [2];
    bit            m_match [2];
    int            pulses [2];

    function automatic bit pat_hit(int d);
        int n = m_q[d].size();
        if (m_len == 0 || n < m_len) return 1'b0;
        for (int j = 0; j < m_len; j++) begin
            if (m_q[d][n-1-j] !== m_pat[2*j +: 2]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [HW-1:0] m_hist(int d);
        logic [HW-1:0] h = '0;
        int n = m_q[d].size();
        for (int j = 0; j < n; j++) h[2*j +: 2] = m_q[d][n-1-j];
        return h;
    endfunction

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_q[d].delete();
                m_idle[d] = 0; m_cnt[d] = 0;
                m_err[d] = 0; m_match[d] = 0;
            end else if (cfg_we) begin
                m_q[d].delete();
                m_idle[d] = 0; m_err[d] = 0; m_match[d] = 0;
            end else if (enable && sym_valid && sym == 2'b01) begin
                m_q[d].delete();
                m_idle[d] = 0; m_err[d] = 1; m_match[d] = 0;
            end else if (enable && sym_valid) begin
                m_q[d].push_back(sym);
                if (m_q[d].size() > MAX) void'(m_q[d].pop_front());
                m_idle[d] = 0;
                m_match[d] = pat_hit(d);
                if (m_match[d]) begin
                    if (m_cnt[d] < ((d == 0) ? 3 : 255)) m_cnt[d]++;
                    if (d == 1) m_q[d].delete();
                end
            end else begin
                m_match[d] = 0;
                if (enable && m_q[d].size() > 0) begin
                    m_idle[d]++;
                    if (m_idle[d] == TO) begin
                        m_q[d].delete();
                        m_idle[d] = 0;
                    end
                end else begin
                    m_idle[d] = 0;
                end
            end
        end
        if (!rst_n) begin
            m_len = SOS_LEN;
            m_pat = HW'(SOS_PATTERN);
        end else if (cfg_we) begin
            m_len = (int'(cfg_len) > MAX) ? MAX : int'(cfg_len);
            m_pat = cfg_pattern;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("match_a", 32'(match_a), 32'(m_match[0]));
        chk("match_b", 32'(match_b), 32'(m_match[1]));
        chk("count_a", 32'(count_a), 32'(m_cnt[0]));
        chk("count_b", 32'(count_b), 32'(m_cnt[1]));
        chk("hist_a", hist_a, m_hist(0));
        chk("hist_b", hist_b, m_hist(1));
        chk("fill_a", 32'(fill_a), 32'(m_q[0].size()));
        chk("fill_b", 32'(fill_b), 32'(m_q[1].size()));
        chk("err_a", 32'(err_a), 32'(m_err[0]));
        chk("err_b", 32'(err_b), 32'(m_err[1]));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        if (match_a) pulses[0]++;
        if (match_b) pulses[1]++;
    endtask

    task automatic idle(input int n);
        sym_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [1:0] s);
        sym_valid = 1'b1;
        sym = s;
        tick();
        sym_valid = 1'b0;
    endtask

    task automatic cfg(input int n, input logic [HW-1:0] p);
        cfg_we = 1'b1;
        cfg_len = LW'(n);
        cfg_pattern = p;
        tick();
        cfg_we = 1'b0;
    endtask

    function automatic logic [1:0] sos_sym(int k);
        logic [21:0] v = SOS_PATTERN;
        return v[2*(10-k) +: 2];
    endfunction

    function automatic logic [1:0] legal_sym();
        int r = $urandom_range(0, 2);
        return (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : 2'b11;
    endfunction

    initial begin
        logic [HW-1:0] p;
        int quiet;

        // Reset state
        rst_n = 1'b0; enable = 1'b1;
        tick(); tick();
        chk("rst_match", 32'(match_a), 32'd0);
        chk("rst_fill", 32'(fill_a), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Default SOS with gaps
        pulses[0] = 0; pulses[1] = 0;
        for (int k = 0; k < 11; k++) begin
            send(sos_sym(k));
            if (k == 10) begin
                chk("sos_match_a", 32'(match_a), 32'd1);
                chk("sos_match_b", 32'(match_b), 32'd1);
                chk("sos_count", 32'(count_a), 32'd1);
                chk("sos_fill", 32'(fill_a), 32'd11);
            end
            idle(1);
        end
        chk("sos_one_cycle", 32'(match_a), 32'd0);
        chk("sos_pulses", 32'(pulses[0]), 32'd1);

        // Overlap vs non-overlap on "..."
        cfg(3, '0);
        pulses[0] = 0; pulses[1] = 0;
        for (int k = 0; k < 5; k++) send(SYM_DOT);
        idle(1);
        chk("ovl_pulses", 32'(pulses[0]), 32'd3);
        chk("ovl_count", 32'(count_a), 32'd3);
        chk("novl_pulses", 32'(pulses[1]), 32'd1);
        chk("novl_fill", 32'(fill_b), 32'd2);

        // Idle timeout flush
        cfg(11, HW'(SOS_PATTERN));
        for (int k = 0; k < 5; k++) send(sos_sym(k));
        for (int i = 1; i <= TO; i++) begin
            tick();
            if (i == TO - 1) chk("to_before", 32'(fill_a), 32'd5);
            if (i == TO) chk("to_flush", 32'(fill_a), 32'd0);
        end
        pulses[0] = 0; pulses[1] = 0;
        for (int k = 0; k < 11; k++) begin
            send(sos_sym(k));
            idle(1);
        end
        chk("to_pulses_a", 32'(pulses[0]), 32'd1);
        chk("to_pulses_b", 32'(pulses[1]), 32'd1);

        // Illegal code mid-sequence
        pulses[0] = 0; pulses[1] = 0;
        for (int k = 0; k < 4; k++) send(sos_sym(k));
        send(SYM_ILLEGAL);
        chk("ill_err", 32'(err_a), 32'd1);
        chk("ill_fill", 32'(fill_a), 32'd0);
        for (int k = 4; k < 11; k++) send(sos_sym(k));
        chk("ill_nomatch", 32'(pulses[0] + pulses[1]), 32'd0);
        cfg(11, HW'(SOS_PATTERN));
        chk("ill_cfg_clear", 32'(err_a), 32'd0);

        // Config collision with a symbol, length clamp to 16
        for (int k = 0; k < 3; k++) send(SYM_DASH);
        for (int k = 0; k < MAX; k++) p[2*k +: 2] = legal_sym();
        sym_valid = 1'b1; sym = SYM_DOT;
        cfg(31, p);
        sym_valid = 1'b0;
        chk("clamp_drop", 32'(fill_a), 32'd0);
        pulses[0] = 0; pulses[1] = 0;
        for (int k = 0; k < MAX; k++) send(p[2*(MAX-1-k) +: 2]);
        chk("clamp_early", 32'(pulses[0]), 32'd1);
        chk("clamp_match", 32'(match_a), 32'd1);

        // len = 0 never matches
        cfg(0, '0);
        pulses[0] = 0; pulses[1] = 0;
        for (int k = 0; k < 24; k++) send(legal_sym());
        chk("len0_pulses", 32'(pulses[0] + pulses[1]), 32'd0);

        // Counter saturation, then reset over a pending match
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        cfg(1, '0);
        for (int k = 0; k < 5; k++) send(SYM_DOT);
        chk("sat_a", 32'(count_a), 32'd3);
        chk("sat_b", 32'(count_b), 32'd5);
        send(SYM_ILLEGAL);
        send(SYM_DOT);
        chk("pre_rst_match", 32'(match_a), 32'd1);
        rst_n = 1'b0; sym_valid = 1'b1; sym = SYM_DOT;
        tick();
        rst_n = 1'b1; sym_valid = 1'b0;
        chk("rst_mid_match", 32'(match_a), 32'd0);
        chk("rst_mid_count", 32'(count_a), 32'd0);
        chk("rst_mid_hist", hist_a, 32'd0);
        chk("rst_mid_fill", 32'(fill_b), 32'd0);

        // Randomized traffic
        quiet = 0;
        for (int c = 0; c < 2500; c++) begin
            cfg_we = ($urandom_range(0, 99) < 3);
            if (cfg_we) begin
                cfg_len = ($urandom_range(0, 3) == 0)
                        ? LW'($urandom_range(0, 20))
                        : LW'($urandom_range(1, 3));
                cfg_pattern = HW'($urandom());
            end
            enable = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 199) == 0) quiet = TO + 5;
            if (quiet > 0) begin
                sym_valid = 1'b0;
                quiet--;
            end else begin
                sym_valid = ($urandom_range(0, 2) != 0);
            end
            sym = ($urandom_range(0, 49) == 0) ? 2'b01 : legal_sym();
            rst_n = ($urandom_range(0, 499) != 0);
            tick();
        end
        cfg_we = 1'b0; sym_valid = 1'b0; rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
